// File: rtl/cmp_pkg.sv
// Shared constants for the comparator arbiter: ASCII relation codes and FSM state encoding.
package cmp_pkg;

  localparam logic [7:0] SIGN_EQ = 8'h3D;
  localparam logic [7:0] SIGN_LT = 8'h3C;
  localparam logic [7:0] SIGN_GT = 8'h3E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the requesters, the response consumer and cmp_arbiter.
interface cmp_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [7:0]             rsp_sign;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sign
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sign
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit above last_grant, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin shared magnitude comparator returning ASCII relation codes.
// Define CMP_ARB_SIGNED_EN to compare operands as two's complement instead of unsigned.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_arbiter_if.slave  bus,
  output logic          busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_a_next;
  logic [WIDTH-1:0] op_b_reg, op_b_next;
  logic [ID_W-1:0]  cur_id_reg, cur_id_next;
  logic [ID_W-1:0]  last_grant_reg, last_grant_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0]  rsp_id_reg, rsp_id_next;
  logic [7:0]       rsp_sign_reg, rsp_sign_next;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_valid;
  logic             a_lt;

  logic [WIDTH-1:0] a_slice [N_REQ];
  logic [WIDTH-1:0] b_slice [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_slice[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_slice[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

`ifdef CMP_ARB_SIGNED_EN
  assign a_lt = $signed(op_a_reg) < $signed(op_b_reg);
`else
  assign a_lt = op_a_reg < op_b_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      cur_id_reg     <= '0;
      last_grant_reg <= ID_W'(N_REQ - 1);
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_sign_reg   <= 8'h00;
    end else begin
      state_reg      <= state_next;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      cur_id_reg     <= cur_id_next;
      last_grant_reg <= last_grant_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_sign_reg   <= rsp_sign_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    op_a_next       = op_a_reg;
    op_b_next       = op_b_reg;
    cur_id_next     = cur_id_reg;
    last_grant_next = last_grant_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_sign_next   = rsp_sign_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          op_a_next       = a_slice[grant_idx];
          op_b_next       = b_slice[grant_idx];
          cur_id_next     = grant_idx;
          last_grant_next = grant_idx;
          state_next      = CMP;
        end
      end
      CMP: begin
        rsp_sign_next  = (op_a_reg == op_b_reg) ? SIGN_EQ : (a_lt ? SIGN_LT : SIGN_GT);
        rsp_id_next    = cur_id_reg;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Acceptance is only offered while idle, so the grant doubles as req_ready.
  assign bus.req_ready = (state_reg == IDLE) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_sign  = rsp_sign_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter: reset, round-robin, backpressure, fairness, signedness, reset abort.
module tb_cmp_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;

  cmp_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  cmp_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // One transaction against requesters already presenting valid; rsp_ready tied high.
  task automatic txn(input string tag, input int exp_id, input logic [7:0] exp_sign);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << exp_id));
    tick();
    chk({tag, "_cmp_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
    chk({tag, "_sign"}, 32'(bus.rsp_sign), 32'(exp_sign));
    $display("txn %s id=%0d sign=%02h", tag, bus.rsp_id, bus.rsp_sign);
    tick();
    chk({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
    #1;
  endtask

  initial begin
    logic [7:0] exp_signed;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_rsp_sign",  32'(bus.rsp_sign),  32'h00);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request, A=B=0
    bus.req_valid = 4'b0001;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    chk("single_busy0", 32'(busy), 32'd0);
    tick();
    bus.req_valid = '0;
    #1;
    chk("single_busy1", 32'(busy), 32'd1);
    chk("single_ready_cmp", 32'(bus.req_ready), 32'd0);
    chk("single_valid_cmp", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("single_busy2", 32'(busy), 32'd1);
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_id",    32'(bus.rsp_id),    32'd0);
    chk("single_sign",  32'(bus.rsp_sign),  32'h3D);
    $display("txn single id=%0d sign=%02h", bus.rsp_id, bus.rsp_sign);
    tick();
    chk("single_valid_end", 32'(bus.rsp_valid), 32'd0);
    chk("single_busy3", 32'(busy), 32'd0);

    // Round-robin: all valid, pairs (21,129) (224,7) (2,7) (9,2)
    do_reset();
    bus.req_a = {8'd9, 8'd2, 8'd224, 8'd21};
    bus.req_b = {8'd2, 8'd7, 8'd7,   8'd129};
    bus.req_valid = 4'b1111;
    #1;
    txn("rr0", 0, 8'h3C);
    txn("rr1", 1, 8'h3E);
    txn("rr2", 2, 8'h3C);
    txn("rr3", 3, 8'h3E);
    txn("rr4", 0, 8'h3C);

    // Backpressure on requester 2, A=B=200
    do_reset();
    bus.req_a = {8'd0, 8'd200, 8'd0, 8'd0};
    bus.req_b = {8'd0, 8'd200, 8'd0, 8'd0};
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid",     32'(bus.rsp_valid), 32'd1);
      chk("bp_id",        32'(bus.rsp_id),    32'd2);
      chk("bp_sign",      32'(bus.rsp_sign),  32'h3D);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    $display("txn backpressure id=%0d sign=%02h", bus.rsp_id, bus.rsp_sign);
    tick();
    chk("bp_released", 32'(bus.rsp_valid), 32'd0);
    chk("bp_next_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;

    // Fairness between requesters 1 and 3
    do_reset();
    bus.req_a = {8'd5, 8'd0, 8'd5, 8'd0};
    bus.req_b = {8'd5, 8'd0, 8'd6, 8'd0};
    bus.req_valid = 4'b1010;
    #1;
    txn("fair0", 1, 8'h3C);
    txn("fair1", 3, 8'h3D);
    txn("fair2", 1, 8'h3C);
    txn("fair3", 3, 8'h3D);

    // Signedness: FF vs 01 on requester 0
`ifdef CMP_ARB_SIGNED_EN
    exp_signed = 8'h3C;
`else
    exp_signed = 8'h3E;
`endif
    do_reset();
    bus.req_a = {24'd0, 8'hFF};
    bus.req_b = {24'd0, 8'h01};
    bus.req_valid = 4'b0001;
    #1;
    txn("signed", 0, exp_signed);

    // Reset while the response is pending
    do_reset();
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    chk("abort_valid_pre", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid_async", 32'(bus.rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    $display("txn abort rsp_valid=%0d", bus.rsp_valid);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("abort_first_grant", 32'(bus.req_ready), 32'h1);
    chk("abort_no_stale", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one WIDTH-bit magnitude comparator between N_REQ requesters. Each requester submits an (A, B) operand pair over a valid/ready handshake.
- Requesters are granted round-robin. The block returns an ASCII relation code ("=", "<", ">") tagged with the requester index.
- It sits between the drill testbench/stimulus agents and the comparator datapath, and owns all sequencing of that datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits
- ID_W, $clog2(N_REQ), width of the response requester index

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  N_REQ  per-requester operand-pair valid
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- req_a  input  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B; same slicing as req_a
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer accept
- rsp_id  output  ID_W  index of the requester this response belongs to
- rsp_sign  output  8  ASCII relation: 8'h3D "=", 8'h3C "<", 8'h3E ">" (A relative to B)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rsp_valid=0; rsp_id=0; rsp_sign=8'h00; req_ready=0; busy=0; round-robin pointer last_grant=N_REQ-1, so requester 0 has first priority.
- FSM states are IDLE, CMP and RESP.
- IDLE:
  - If any req_valid bit is set, grant g = the first set bit searching upward from last_grant+1, modulo N_REQ.
  - req_ready[g]=1 combinationally in this cycle; the handshake completes this cycle.
  - On the clock edge: latch req_a/req_b slice g into op_a/op_b, set cur_id=g, last_grant=g, and go to CMP.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- CMP (one cycle):
  - rsp_sign <= op_a==op_b ? "=" : (op_a<op_b ? "<" : ">").
  - rsp_id <= cur_id; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_sign stable until rsp_ready=1.
  - On the edge where rsp_valid and rsp_ready are both 1: rsp_valid <= 0 and go to IDLE.
  - rsp_ready is ignored outside RESP.
- Latency: handshake in cycle T; rsp_valid first high at edge T+2. Minimum of 3 cycles per transaction with rsp_ready tied high.
- req_ready is 0 in CMP and RESP. Requesters hold valid and operands until accepted.
- Simultaneous requests: exactly one is granted; the others are untouched.
- Fairness: a continuously valid requester is served within N_REQ transactions.
- A requester may drop req_valid before it is granted; no grant is then issued to it.
- Comparison is unsigned by default over the full WIDTH bits; no width extension or truncation.
- Reset mid-transaction aborts it: the response is lost, the pointer resets, and no stale rsp_valid appears.

Optional Feature:
- Macro CMP_ARB_SIGNED_EN.
- Defined: operands are compared as two's complement, e.g. 8'hFF < 8'h01 gives "<".
- Undefined: unsigned compare, so 8'hFF > 8'h01 gives ">".
- Ports, latency and handshakes are identical in both builds.

Decomposition:
- Package cmp_pkg holds:
  - ASCII constants SIGN_EQ=8'h3D, SIGN_LT=8'h3C, SIGN_GT=8'h3E
  - FSM state encoding (IDLE=2'd0, CMP=2'd1, RESP=2'd2)
- One sub-module, rr_arbiter: N_REQ-bit request vector plus last_grant in, one-hot grant plus grant index out. Purely combinational; the pointer register stays in cmp_arbiter.
- The compare itself stays inline in the CMP state.

Test Plan:
- Single request: req_valid=4'b0001, A=0, B=0, rsp_ready=1 -> req_ready[0] high in cycle 0; rsp_valid at edge 2 with rsp_id=0, rsp_sign=8'h3D; busy high for 2 cycles.
- All four requesters valid continuously, with pairs (21,129), (224,7), (2,7), (9,2) -> grant order 0,1,2,3,0; signs "<", ">", "<", ">"; each transaction 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_sign stable; req_ready=0 throughout; one transaction completes when rsp_ready rises.
- Fairness: requesters 1 and 3 always valid, last grant=1 -> next grant 3, then 1, alternating.
- Signedness: A=8'hFF, B=8'h01 -> ">" without CMP_ARB_SIGNED_EN; "<" with it.
- Reset in RESP: assert rst_n=0 while rsp_valid=1 -> rsp_valid drops immediately (asynchronously); after release, a request from requester 0 is granted first.
